gsim_rotreg: RTL and testbench
==============================

# gsim_rotreg

Parametrised circular register bank for the GSIM datapath, the successor to the fixed 16-entry, three-mode shift register. It loads DEPTH words through a valid/ready stream, then performs arbitrary-amount rotations on command. While rotating it can optionally inject a new word, and it exposes symmetric tap pairs to the solver arithmetic. A phase counter tracks the cumulative rotation so downstream logic always knows which logical element sits in slot 0.

## Interface

Parameters:
- WIDTH, 32: word width in bits.
- DEPTH, 16: number of entries; power of two, at least 4.
- NTAP, 3: number of tap pairs; at most DEPTH/2 − 1.

Ports (LG = log2(DEPTH)):
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- clear, input, 1: synchronous clear. Zeroes all entries, phase and count, and returns the block to IDLE.
- start, input, 1: in IDLE, begins the LOAD phase.
- in_valid, input, 1: input word valid.
- in_ready, output, 1: input word accepted when in_valid & in_ready.
- in_data, input, WIDTH: input word.
- cmd_valid, input, 1: rotate command valid.
- cmd_ready, output, 1: rotate command accepted when cmd_valid & cmd_ready.
- cmd_shamt, input, LG: rotate amount, 0..DEPTH−1.
- loaded, output, 1: high in RUN.
- phase, output, LG: cumulative rotation mod DEPTH.
- tap_hi, output, NTAP*WIDTH: slice k = MEM[DEPTH−1−k].
- tap_lo, output, NTAP*WIDTH: slice k = MEM[k+1].

## Operation

- States are IDLE, LOAD and RUN.
- Reset: all entries 0, state IDLE, phase 0, load count 0. Outputs: in_ready 0, cmd_ready 0, loaded 0, taps 0.
- IDLE:
  - in_ready = 0, cmd_ready = 0.
  - start → LOAD; the load count is set to 0 and entry contents are unchanged.
- LOAD:
  - in_ready = 1, cmd_ready = 0.
  - Each accepted word shifts every entry down by one (MEM[i] ← MEM[i+1]) and writes in_data to MEM[DEPTH−1].
  - After DEPTH accepts → RUN and phase ← 0. The first word loaded ends in MEM[0].
- RUN:
  - cmd_ready = 1, in_ready = 1, loaded = 1.
  - An accepted command rotates left by s = cmd_shamt: MEM[i] ← MEM[(i+s) mod DEPTH], and phase ← (phase+s) mod DEPTH.
  - Injection: when in_valid is accepted in the same cycle, MEM[DEPTH−1] ← in_data after the rotation is applied.
  - in_valid without cmd_valid writes MEM[DEPTH−1] with no rotation.
  - s = 0 holds all entries; injection still applies.
  - start is ignored.
- clear has priority over start, data and commands in every state.
- Wrap-around: phase and indices are modulo DEPTH; no overflow flag.

## Timing

- Taps, phase and loaded are registered and reflect an accepted transfer on the next clock edge; the block adds no other latency.
- Ready signals are combinational from state only, never from the valid inputs.
- LOAD takes exactly DEPTH accepted words. Stalls (in_valid low) are allowed and hold state.
- Reset asserted mid-LOAD or mid-RUN aborts immediately to reset values; no partial state survives.
- clear mid-LOAD discards the partially loaded contents (all entries zeroed).
- The IDLE→LOAD transition takes one cycle, so the first word can be accepted in the cycle after start.

## Configuration

- With GSIM_ROTREG_BIDIR_EN defined:
  - Adds input cmd_dir (1 bit).
  - cmd_dir = 1 rotates right: MEM[i] ← MEM[(i−s) mod DEPTH], and phase ← (phase−s) mod DEPTH.
  - Injection still targets MEM[DEPTH−1] after the rotation.
- Without GSIM_ROTREG_BIDIR_EN: the cmd_dir port is absent and every rotation is left.

## Structure

- Package gsim_rotreg_pkg: state enum (IDLE, LOAD, RUN) and rotation-direction constants (ROT_LEFT, ROT_RIGHT).
- Sub-module gsim_rot_barrel: a combinational log2(DEPTH)-stage barrel rotator over the packed entry vector, with a direction input.
- Top level holds the FSM, load counter, phase register, injection mux and entry registers.

## Test plan

All scenarios use DEPTH = 16, WIDTH = 32, NTAP = 3.

- Reset, then start, then load 0..15 with in_valid held high → loaded rises after the 16th accept, phase = 0. Taps: tap_lo = {1,2,3}, tap_hi = {15,14,13}.
- Loaded 0..15, then a cmd with shamt = 5 → MEM[0] = 5, MEM[15] = 4, phase = 5. Then shamt = 12 → phase = 1, MEM[0] = 1.
- Loaded 0..15, then shamt = 4 with simultaneous in_data = 0xDEAD → MEM[15] = 0xDEAD, MEM[11] = 15, MEM[0] = 4.
- LOAD with in_valid toggling 1-0-1 → exactly 16 accepts before RUN; no cmd_ready during LOAD.
- clear during RUN with cmd_valid high → all taps 0, state IDLE, phase 0, command not applied. Also assert rst_n mid-LOAD → in_ready 0 immediately.
- BIDIR build: loaded 0..15, then right rotate by 3 → MEM[0] = 13, phase = 13. Then left rotate by 3 → original order restored, phase = 0.

Source files
------------

// File: rtl/gsim_rotreg_pkg.sv
// gsim_rotreg shared types: FSM state encoding and rotation direction.
// Imported by the rotator bank top and its barrel shifter.
package gsim_rotreg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic ROT_LEFT  = 1'b0;
    localparam logic ROT_RIGHT = 1'b1;

endpackage

// File: rtl/gsim_rot_barrel.sv
// gsim_rot_barrel: combinational log2(DEPTH)-stage barrel rotator over a
// packed entry vector. Left: out[i] = in[(i+s)%D]; right: out[i] = in[(i-s)%D].
module gsim_rot_barrel
    import gsim_rotreg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int LG   = $clog2(DEPTH)
) (
    input  logic [DEPTH*WIDTH-1:0] data_i,
    input  logic [LG-1:0]          shamt_i,
    input  logic                   dir_i,
    output logic [DEPTH*WIDTH-1:0] data_o
);

    logic [DEPTH*WIDTH-1:0] cur;
    logic [DEPTH*WIDTH-1:0] nxt;

    // Each stage k conditionally rotates by 2^k entries in the chosen direction.
    always_comb begin
        cur = data_i;
        nxt = data_i;
        for (int k = 0; k < LG; k++) begin
            nxt = cur;
            if (shamt_i[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (dir_i == ROT_RIGHT) begin
                        nxt[i*WIDTH +: WIDTH] =
                            cur[((i - (1 << k)) & (DEPTH - 1))*WIDTH +: WIDTH];
                    end else begin
                        nxt[i*WIDTH +: WIDTH] =
                            cur[((i + (1 << k)) & (DEPTH - 1))*WIDTH +: WIDTH];
                    end
                end
            end
            cur = nxt;
        end
        data_o = cur;
    end

endmodule

// File: rtl/gsim_rotreg.sv
// gsim_rotreg: circular register bank with stream load, arbitrary rotation,
// injection and symmetric taps. GSIM_ROTREG_BIDIR_EN adds right rotation (cmd_dir).
module gsim_rotreg
    import gsim_rotreg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int NTAP  = 3,
    localparam int LG   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LG-1:0]         cmd_shamt,
`ifdef GSIM_ROTREG_BIDIR_EN
    input  logic                  cmd_dir,
`endif
    output logic                  loaded,
    output logic [LG-1:0]         phase,
    output logic [NTAP*WIDTH-1:0] tap_hi,
    output logic [NTAP*WIDTH-1:0] tap_lo
);

    localparam int MW = DEPTH * WIDTH;

    state_e            state_q, state_d;
    logic [LG-1:0]     cnt_q, cnt_d;
    logic [LG-1:0]     phase_q, phase_d;
    logic [MW-1:0]     mem_q, mem_d;
    logic [MW-1:0]     rot_w;
    logic [LG-1:0]     rot_amt;
    logic              rot_dir;
    logic              in_fire;
    logic              cmd_fire;
    logic              last_word;

    assign in_ready  = (state_q == LOAD) || (state_q == RUN);
    assign cmd_ready = (state_q == RUN);
    assign loaded    = (state_q == RUN);
    assign phase     = phase_q;

    assign in_fire   = in_valid & in_ready;
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign last_word = (cnt_q == LG'(DEPTH - 1));

`ifdef GSIM_ROTREG_BIDIR_EN
    assign rot_dir = cmd_dir;
`else
    assign rot_dir = ROT_LEFT;
`endif

    // A zero amount makes the rotator a pass-through for injection-only writes.
    assign rot_amt = cmd_fire ? cmd_shamt : '0;

    gsim_rot_barrel #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_barrel (
        .data_i  (mem_q),
        .shamt_i (rot_amt),
        .dir_i   (rot_dir),
        .data_o  (rot_w)
    );

    for (genvar k = 0; k < NTAP; k++) begin : g_tap
        assign tap_lo[k*WIDTH +: WIDTH] = mem_q[(k+1)*WIDTH +: WIDTH];
        assign tap_hi[k*WIDTH +: WIDTH] = mem_q[(DEPTH-1-k)*WIDTH +: WIDTH];
    end

    // Next-state logic: IDLE -> LOAD on start, LOAD -> RUN after DEPTH words.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        cnt_d = cnt_q + LG'(1);
                        if (last_word) begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Datapath: load shifting, rotation with injection, and phase tracking.
    always_comb begin
        mem_d   = mem_q;
        phase_d = phase_q;
        if (clear) begin
            mem_d   = '0;
            phase_d = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_fire) begin
                        mem_d = {in_data, mem_q[MW-1:WIDTH]};
                        if (last_word) begin
                            phase_d = '0;
                        end
                    end
                end
                RUN: begin
                    if (cmd_fire || in_fire) begin
                        mem_d = rot_w;
                    end
                    if (in_fire) begin
                        mem_d[(DEPTH-1)*WIDTH +: WIDTH] = in_data;
                    end
                    if (cmd_fire) begin
                        if (rot_dir == ROT_RIGHT) begin
                            phase_d = phase_q - cmd_shamt;
                        end else begin
                            phase_d = phase_q + cmd_shamt;
                        end
                    end
                end
                default: begin
                    mem_d   = mem_q;
                    phase_d = phase_q;
                end
            endcase
        end
    end

    // State, counter, phase and entry registers with async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_gsim_rotreg.sv
// Scoreboard bench for gsim_rotreg (DEPTH 16, WIDTH 32, NTAP 3).
// Define GSIM_ROTREG_BIDIR_EN to also exercise right rotation.
module tb_gsim_rotreg;

    localparam int W = 32;
    localparam int D = 16;
    localparam int N = 3;

    typedef logic [D-1:0][W-1:0] mem_t;

    typedef struct {
        string      nm;
        logic [3:0] ph;
        logic       ld;
        logic       ir;
        logic       cr;
        mem_t       mem;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_shamt;
`ifdef GSIM_ROTREG_BIDIR_EN
    logic         cmd_dir;
`endif
    logic         loaded;
    logic [3:0]   phase;
    logic [N*W-1:0] tap_hi;
    logic [N*W-1:0] tap_lo;

    exp_t q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    gsim_rotreg #(
        .WIDTH (W),
        .DEPTH (D),
        .NTAP  (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_shamt (cmd_shamt),
`ifdef GSIM_ROTREG_BIDIR_EN
        .cmd_dir   (cmd_dir),
`endif
        .loaded    (loaded),
        .phase     (phase),
        .tap_hi    (tap_hi),
        .tap_lo    (tap_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mem[i] = (i + off) mod 16: contents after loading 0..15 and rotating by off.
    function automatic mem_t seq(input int off);
        mem_t r;
        for (int i = 0; i < D; i++) r[i] = W'((i + off) % D);
        return r;
    endfunction

    // Contents after k words 0..k-1 were shifted into a zeroed bank.
    function automatic mem_t partial(input int k);
        mem_t r;
        r = '0;
        for (int j = 0; j < k; j++) r[D-k+j] = W'(j);
        return r;
    endfunction

    task automatic cmp(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Clock edge, then queue the expected post-edge state for the monitor.
    task automatic step(input string nm, input logic [3:0] ph,
                        input logic ld, input logic ir, input logic cr,
                        input mem_t mem);
        exp_t e;
        @(posedge clk);
        e.nm  = nm;
        e.ph  = ph;
        e.ld  = ld;
        e.ir  = ir;
        e.cr  = cr;
        e.mem = mem;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: after every edge with a pending expectation, compare outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                cmp({e.nm, ".phase"}, 512'(phase), 512'(e.ph));
                cmp({e.nm, ".loaded"}, 512'(loaded), 512'(e.ld));
                cmp({e.nm, ".in_ready"}, 512'(in_ready), 512'(e.ir));
                cmp({e.nm, ".cmd_ready"}, 512'(cmd_ready), 512'(e.cr));
                cmp({e.nm, ".mem"}, 512'(dut.mem_q), 512'(e.mem));
                cmp({e.nm, ".tap_lo"}, 512'(tap_lo),
                    512'({e.mem[3], e.mem[2], e.mem[1]}));
                cmp({e.nm, ".tap_hi"}, 512'(tap_hi),
                    512'({e.mem[13], e.mem[14], e.mem[15]}));
            end
        end
    end

    // Load words 0..15 from IDLE; optionally insert a stall after each word.
    task automatic load_all(input string nm, input bit toggle);
        start = 1'b1;
        step({nm, ".start"}, 4'd0, 1'b0, 1'b1, 1'b0, '0);
        start = 1'b0;
        for (int k = 1; k <= D; k++) begin
            in_valid = 1'b1;
            in_data  = W'(k - 1);
            step({nm, ".word"}, 4'd0, k == D, 1'b1, k == D, partial(k));
            in_valid = 1'b0;
            if (toggle) begin
                step({nm, ".stall"}, 4'd0, k == D, 1'b1, k == D, partial(k));
            end
        end
    endtask

    initial begin
        mem_t m;
        rst_n     = 1'b0;
        clear     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        cmd_valid = 1'b0;
        cmd_shamt = '0;
`ifdef GSIM_ROTREG_BIDIR_EN
        cmd_dir   = 1'b0;
`endif
        @(negedge clk);
        step("reset", 4'd0, 1'b0, 1'b0, 1'b0, '0);
        rst_n = 1'b1;
        step("idle", 4'd0, 1'b0, 1'b0, 1'b0, '0);

        load_all("load", 1'b0);

        cmd_valid = 1'b1;
        cmd_shamt = 4'd5;
        step("rot5", 4'd5, 1'b1, 1'b1, 1'b1, seq(5));
        cmd_shamt = 4'd12;
        step("rot12", 4'd1, 1'b1, 1'b1, 1'b1, seq(1));
        cmd_shamt = 4'd15;
        step("rot15", 4'd0, 1'b1, 1'b1, 1'b1, seq(0));

        cmd_shamt = 4'd4;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD;
        m = seq(4);
        m[15] = 32'hDEAD;
        step("inject", 4'd4, 1'b1, 1'b1, 1'b1, m);

        cmd_valid = 1'b0;
        in_data   = 32'h1234;
        m[15] = 32'h1234;
        step("in_only", 4'd4, 1'b1, 1'b1, 1'b1, m);
        in_valid  = 1'b0;

        cmd_valid = 1'b1;
        cmd_shamt = 4'd0;
        step("rot0", 4'd4, 1'b1, 1'b1, 1'b1, m);
        cmd_valid = 1'b0;

        start = 1'b1;
        step("start_run", 4'd4, 1'b1, 1'b1, 1'b1, m);
        start = 1'b0;

        clear     = 1'b1;
        cmd_valid = 1'b1;
        cmd_shamt = 4'd7;
        in_valid  = 1'b1;
        step("clear", 4'd0, 1'b0, 1'b0, 1'b0, '0);
        clear     = 1'b0;
        cmd_valid = 1'b0;
        in_valid  = 1'b0;

        load_all("tload", 1'b1);

`ifdef GSIM_ROTREG_BIDIR_EN
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_shamt = 4'd3;
        step("rotr3", 4'd13, 1'b1, 1'b1, 1'b1, seq(13));
        cmd_dir   = 1'b0;
        step("rotl3", 4'd0, 1'b1, 1'b1, 1'b1, seq(0));
        cmd_valid = 1'b0;
`endif

        clear = 1'b1;
        step("clear2", 4'd0, 1'b0, 1'b0, 1'b0, '0);
        clear = 1'b0;
        start = 1'b1;
        step("start2", 4'd0, 1'b0, 1'b1, 1'b0, '0);
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            in_data  = W'(k - 1);
            step("pload", 4'd0, 1'b0, 1'b1, 1'b0, partial(k));
        end
        rst_n = 1'b0;
        #1;
        cmp("rst_mid.in_ready", 512'(in_ready), 512'(0));
        cmp("rst_mid.mem", 512'(dut.mem_q), 512'(0));
        step("rst_mid", 4'd0, 1'b0, 1'b0, 1'b0, '0);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        load_all("reload", 1'b0);

        repeat (3) @(posedge clk);
        #2;
        cmp("queue_drained", 512'(q.size()), 512'(0));
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
